// File: rtl/xbar_pkg.sv
// Crossbar shared types and helpers.
// Arbiter state enum, burst-count width, grant encoding helpers.
package xbar_pkg;

  typedef enum logic {
    IDLE,
    DATA
  } wr_arb_state_e;

  localparam int XBAR_LEN_W  = 8;
  localparam int BURST_CNT_W = XBAR_LEN_W + 1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // "No grant" is the MSB alone set in a w-bit grant field.
  function automatic logic [31:0] no_grant(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/write_burst_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req at or above start, wrapping.
// Ports: req, start -> found, idx.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  function automatic int wrap(input int s, input int i);
    int j;
    j = s + i;
    return (j >= N) ? j - N : j;
  endfunction

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap(int'(start), i)]) begin
        found = 1'b1;
        idx   = W'(wrap(int'(start), i));
      end
    end
  end

endmodule

// File: rtl/write_burst_arbiter.sv
// Per-slave AW arbiter; locks W routing to the winner for its whole burst.
// Ports: AXI clock/reset, master AW FIFO heads, slave FIFO full, W handshake.
module write_burst_arbiter
  import xbar_pkg::*;
#(
  parameter int MASTERS           = 2,
  parameter int SLAVES            = 2,
  parameter int I_AM_SLAVE_NUMBER = 0,
  parameter int LEN_W             = XBAR_LEN_W
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic [MASTERS-1:0] master_fifo_empty,
  input  logic [MASTERS-1:0][clog2_min1(SLAVES)-1:0]
               master_slave_dest,
  input  logic [MASTERS-1:0][LEN_W-1:0] master_awlen,
  input  logic slave_fifo_full,
  input  logic w_valid,
  input  logic w_ready,
  input  logic w_last,
  output logic push_to_fifo,
  output logic [clog2_min1(MASTERS):0] grant_master_number,
  output logic w_route_valid,
  output logic [clog2_min1(MASTERS)-1:0] w_route_master,
  output logic len_error
);

  localparam int MW = clog2_min1(MASTERS);
  localparam int GW = MW + 1;
  localparam int CW = LEN_W + 1;
  localparam logic [GW-1:0] NO_GRANT = GW'(no_grant(GW));

  wr_arb_state_e   state, state_d;
  logic [MW-1:0]   rr_ptr, rr_ptr_d;
  logic [MW-1:0]   win_q, win_d;
  logic [CW-1:0]   beats_left, beats_d;
  logic            err_d;
  logic [MASTERS-1:0] req;
  logic            found;
  logic [MW-1:0]   winner;
  logic            beat;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERS; i++) begin
      req[i] = ~master_fifo_empty[i] &
               (32'(master_slave_dest[i]) ==
                32'(I_AM_SLAVE_NUMBER));
    end
  end

  rr_picker #(
    .N(MASTERS),
    .W(MW)
  ) u_pick (
    .req  (req),
    .start(rr_ptr),
    .found(found),
    .idx  (winner)
  );

  assign beat = w_valid & w_ready;

  always_comb begin
    state_d             = state;
    rr_ptr_d            = rr_ptr;
    win_d               = win_q;
    beats_d             = beats_left;
    err_d               = 1'b0;
    push_to_fifo        = 1'b0;
    grant_master_number = NO_GRANT;
    w_route_valid       = 1'b0;
    w_route_master      = '0;
    unique case (state)
      IDLE: begin
        push_to_fifo = found & ~slave_fifo_full;
        if (push_to_fifo) begin
          grant_master_number = {1'b0, winner};
          win_d    = winner;
          beats_d  = CW'(master_awlen[winner]) + CW'(1);
          rr_ptr_d = (winner == MW'(MASTERS - 1))
                     ? '0 : winner + 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        w_route_valid  = 1'b1;
        w_route_master = win_q;
        if (beat) begin
          beats_d = beats_left - CW'(1);
          if (beats_left == CW'(1)) begin
            // Counter decides the end; WLAST only cross-checks it.
            err_d   = ~w_last;
            state_d = IDLE;
          end else begin
            err_d = w_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_q      <= '0;
      beats_left <= '0;
      len_error  <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      win_q      <= win_d;
      beats_left <= beats_d;
      len_error  <= err_d;
    end
  end

endmodule
